branch_resolve_unit: RTL

- Consumer end of the 2-bit branch predictor: tracks in-flight predictions from fetch and checks each one against the actual outcome from execute.
- Sends the actual taken/not-taken outcome back to the predictor as a training update.
- Issues a redirect to fetch on a mispredict and flushes all younger in-flight predictions.

---
 rtl/branch_resolve_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Consumer end of the 2-bit branch predictor. Fetch pushes each prediction
//   into a small in-flight queue. Execute resolves branches oldest-first. Each
//   resolution is compared against the queued prediction. The actual outcome
//   is sent back to the predictor as a training update. A mispredict redirects
//   fetch and flushes every younger in-flight prediction.
//
// Parameters:
//   DEPTH   number of in-flight entries (power of 2, >= 2)
//   ADDR_W  PC / target width
//
// Optional feature:
//   `define BRU_PERF_CNT_EN enables the saturating performance counters
//   branch_cnt and mispred_cnt. When it is undefined, both outputs are tied
//   to 0 and no counter flops exist.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   pred_valid/ready  handshake from fetch (ready depends on registered count)
//   pred_pc           PC of the predicted branch
//   pred_taken        predicted direction
//   pred_target       predicted taken target
//   res_valid         execute resolves the oldest in-flight branch
//   res_taken         actual direction
//   res_target        actual taken target
//   upd_valid         training pulse to the predictor (1 cycle after res)
//   upd_pc            PC being trained
//   upd_taken         actual outcome
//   redirect_valid    mispredict pulse to fetch
//   redirect_pc       correct next PC
//   res_error         pulse: a resolution arrived while the queue was empty
//   count             occupied entries
//   branch_cnt        resolved branches (optional)
//   mispred_cnt       mispredicts (optional)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    output logic                       pred_ready,
    input  logic [ADDR_W-1:0]          pred_pc,
    input  logic                       pred_taken,
    input  logic [ADDR_W-1:0]          pred_target,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic [ADDR_W-1:0]          res_target,
    output logic                       upd_valid,
    output logic [ADDR_W-1:0]          upd_pc,
    output logic                       upd_taken,
    output logic                       redirect_valid,
    output logic [ADDR_W-1:0]          redirect_pc,
    output logic                       res_error,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                branch_cnt,
    output logic [31:0]                mispred_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Queue storage (data only, never reset)
    logic [ADDR_W-1:0] r_q_pc     [DEPTH];
    logic              r_q_taken  [DEPTH];
    logic [ADDR_W-1:0] r_q_target [DEPTH];

    // Control state
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    // Registered outputs
    logic              r_upd_valid;
    logic [ADDR_W-1:0] r_upd_pc;
    logic              r_upd_taken;
    logic              r_redirect_valid;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic              r_res_error;

    // Combinational decode
    logic              w_full;
    logic              w_empty;
    logic              w_enq;
    logic              w_pop;
    logic              w_mispred;
    logic [ADDR_W-1:0] w_h_pc;
    logic              w_h_taken;
    logic [ADDR_W-1:0] w_h_target;
    logic [ADDR_W-1:0] w_fallthru;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign pred_ready = ~w_full;

    assign w_enq      = pred_valid & ~w_full;
    assign w_pop      = res_valid & ~w_empty;

    assign w_h_pc     = r_q_pc[r_head];
    assign w_h_taken  = r_q_taken[r_head];
    assign w_h_target = r_q_target[r_head];

    // Sequential fall-through PC; the add wraps at the top of the address space.
    assign w_fallthru = w_h_pc + ADDR_W'(4);

    // A direction mismatch, or the right direction with the wrong target.
    assign w_mispred  = w_pop &
                        ((res_taken != w_h_taken) |
                         (res_taken & w_h_taken & (res_target != w_h_target)));

    // ---- Queue storage write ----
    // The write is harmless on a flush cycle: the flush resets the tail
    // pointer, so the written slot is never treated as occupied.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_pc[r_tail]     <= pred_pc;
            r_q_taken[r_tail]  <= pred_taken;
            r_q_target[r_tail] <= pred_target;
        end
    end

    // ---- Queue pointers and occupancy ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_mispred) begin
            // Flush: every younger entry is wrong-path. A same-cycle enqueue
            // is dropped as well.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + PTR_W'(1);
            if (w_pop) r_head <= r_head + PTR_W'(1);
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---- Resolution output stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_upd_valid      <= 1'b0;
            r_upd_pc         <= '0;
            r_upd_taken      <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_res_error      <= 1'b0;
        end else begin
            r_upd_valid      <= w_pop;
            r_redirect_valid <= w_mispred;
            r_res_error      <= res_valid & w_empty;
            if (w_pop) begin
                r_upd_pc    <= w_h_pc;
                r_upd_taken <= res_taken;
            end
            if (w_mispred) begin
                r_redirect_pc <= res_taken ? res_target : w_fallthru;
            end
        end
    end

    assign upd_valid      = r_upd_valid;
    assign upd_pc         = r_upd_pc;
    assign upd_taken      = r_upd_taken;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign res_error      = r_res_error;
    assign count          = r_count;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    // Increment, holding at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ---- Performance counters (updated at the pop edge) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_pop)     r_branch_cnt  <= sat_inc(r_branch_cnt);
            if (w_mispred) r_mispred_cnt <= sat_inc(r_mispred_cnt);
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
`else
    assign branch_cnt  = 32'd0;
    assign mispred_cnt = 32'd0;
`endif

endmodule
